// File: rtl/framebuffer_swap.sv
// Double-buffered 8-bit framebuffer: the raycaster renders into the back bank, the
// display reads the front bank, banks swap on a vblank rising edge. Optional back-bank
// clear after each swap is enabled by defining FB_CLEAR_EN.
//
// state    | meaning
// CLEAR    | fill back bank with CLEAR_COLOR, one byte per cycle (FB_CLEAR_EN only)
// KICK     | pulse frame_start to the raycaster
// RENDER   | accept pixels into the back bank until frame_done
// WAIT_VBL | hold finished frame until the next vblank rising edge, then swap
module framebuffer_swap #(
  parameter int         WIDTH       = 160,
  parameter int         HEIGHT      = 120,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  px_x,
  input  logic [6:0]  px_y,
  input  logic [7:0]  color,
  input  logic        px_valid,
  input  logic        frame_done,
  input  logic        vblank,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic [7:0]  rd_color,
  output logic        frame_start,
  output logic        front_bank,
  output logic [15:0] frame_count,
  output logic        px_drop
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {CLEAR, KICK, RENDER, WAIT_VBL} state_t;
  localparam state_t INIT_STATE = CLEAR;
`else
  typedef enum logic [1:0] {KICK, RENDER, WAIT_VBL} state_t;
  localparam state_t INIT_STATE = KICK;
`endif

  state_t          state, state_nxt;
  logic            vblank_q;
  logic            px_ok, rd_ok;
  logic [AW-1:0]   px_addr, rd_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      wr_data;
  logic            swap, kick;

  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];

  // Products taken at 32 bits, then narrowed; the in-range result always fits AW bits.
  assign px_addr = AW'(32'(px_y) * WIDTH + 32'(px_x));
  assign rd_addr = AW'(32'(rd_y) * WIDTH + 32'(rd_x));
  assign px_ok   = px_valid && (state == RENDER) && (32'(px_x) < WIDTH) && (32'(px_y) < HEIGHT);
  assign rd_ok   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);

`ifdef FB_CLEAR_EN
  logic [AW-1:0] clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    else                     clr_addr <= '0;
  end
`endif

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = px_addr;
    wr_data   = CLEAR_COLOR;
    swap      = 1'b0;
    kick      = 1'b0;
    case (state)
`ifdef FB_CLEAR_EN
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        if (clr_addr == AW'(DEPTH - 1)) state_nxt = KICK;
      end
`endif
      KICK: begin
        kick      = 1'b1;
        state_nxt = RENDER;
      end
      RENDER: begin
        wr_en   = px_ok;
        wr_data = color;
        if (frame_done) state_nxt = WAIT_VBL;
      end
      WAIT_VBL: begin
        if (vblank && !vblank_q) begin
          swap      = 1'b1;
          state_nxt = INIT_STATE;
        end
      end
      default: state_nxt = INIT_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_STATE;
      vblank_q    <= 1'b0;
      front_bank  <= 1'b0;
      frame_count <= 16'h0000;
      frame_start <= 1'b0;
      px_drop     <= 1'b0;
      rd_color    <= 8'h00;
    end else begin
      state       <= state_nxt;
      vblank_q    <= vblank;
      frame_start <= kick;
      if (swap) begin
        front_bank  <= ~front_bank;
        frame_count <= frame_count + 16'h0001;
      end
      if (px_valid && !px_ok) px_drop <= 1'b1;
      if (rd_ok) rd_color <= front_bank ? mem1[rd_addr] : mem0[rd_addr];
      else       rd_color <= 8'h00;
    end
  end

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_bank) mem0[wr_addr] <= wr_data;
      else            mem1[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/framebuffer_swap.md
FRAMEBUFFER_SWAP -- requirements
Module: framebuffer_swap

Interface
REQ-001 SHALL have parameter WIDTH, default 160, visible columns per frame.
REQ-002 SHALL have parameter HEIGHT, default 120, visible rows per frame.
REQ-003 SHALL have parameter CLEAR_COLOR, default 8'h00, fill value used by the back-buffer clear.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports px_x, px_y, color, px_valid: inputs, 8/7/8/1 bits, pixel stream from the raycaster.
REQ-007 SHALL have port frame_done, input, 1, one-cycle pulse from the raycaster marking the last pixel.
REQ-008 SHALL have port vblank, input, 1, display vertical-blank level.
REQ-009 SHALL have ports rd_x, rd_y: inputs, 8/7 bits, display read coordinate.
REQ-010 SHALL have port rd_color, output, 8, registered front-buffer pixel.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse to the raycaster.
REQ-012 SHALL have port front_bank, output, 1, bank currently displayed.
REQ-013 SHALL have port frame_count, output, 16, completed swaps, wraps 16'hFFFF->0.
REQ-014 SHALL have port px_drop, output, 1, sticky flag set when any valid pixel is discarded.

Function
REQ-015 SHALL hold two banks of WIDTH*HEIGHT bytes; address = y*WIDTH + x within a bank.
REQ-016 SHALL implement states CLEAR, KICK, RENDER, WAIT_VBL.
REQ-017 KICK SHALL assert frame_start for exactly one cycle, then enter RENDER.
REQ-018 In RENDER, px_valid with px_x<WIDTH and px_y<HEIGHT SHALL write color to the back bank (~front_bank) at the next clock edge.
REQ-019 A pixel with px_x>=WIDTH or px_y>=HEIGHT, or arriving outside RENDER, SHALL NOT be written and SHALL set px_drop.
REQ-020 frame_done in RENDER SHALL move to WAIT_VBL; a pixel in the same cycle SHALL still be written.
REQ-021 frame_done outside RENDER SHALL be ignored.
REQ-022 WAIT_VBL SHALL swap only on a vblank rising edge (vblank=1, previous-cycle vblank=0); vblank already high on entry SHALL wait for the next edge.
REQ-023 On swap: front_bank SHALL toggle, frame_count SHALL increment, and the state SHALL go to CLEAR (macro defined) or KICK.
REQ-024 Reads SHALL return rd_color from the front bank one cycle after rd_x/rd_y are presented; an out-of-range coordinate SHALL return 8'h00.
REQ-025 Writes SHALL target only the back bank, so reads SHALL never observe a partially rendered frame.
REQ-026 The y*WIDTH product SHALL be computed at full width (15 bits for defaults) without truncation.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state CLEAR (macro defined) or KICK, front_bank=0, frame_start=0, rd_color=0, frame_count=0, px_drop=0.
REQ-028 Reset mid-clear or mid-render SHALL abort that operation; bank memory contents SHALL NOT be reset.
REQ-029 The first frame_start after reset release SHALL occur only after the state has reached KICK.

Configuration
REQ-030 With macro FB_CLEAR_EN defined, CLEAR SHALL write CLEAR_COLOR to every back-bank address, one per cycle, in ascending order (WIDTH*HEIGHT cycles), then enter KICK; pixels during CLEAR SHALL be dropped per REQ-019.
REQ-031 Without FB_CLEAR_EN, the CLEAR state and its counter SHALL be absent, the post-swap and post-reset state SHALL be KICK, and the back bank SHALL retain the previous contents.

Verification
REQ-032 Reset release, FB_CLEAR_EN undefined -> frame_start high for exactly 1 cycle within 2 cycles; front_bank=0.
REQ-033 Write px (5,3)=8'hA7, frame_done, vblank edge -> front_bank=1, frame_count=1; read (5,3) -> rd_color=8'hA7 one cycle later.
REQ-034 px_x=160, px_y=10 valid -> no write; px_drop=1 and stays 1 until reset.
REQ-035 frame_done with vblank held high -> no swap until vblank falls and rises again; then swap on that edge.
REQ-036 FB_CLEAR_EN defined, after swap -> 19200 clear cycles, all back-bank bytes = CLEAR_COLOR, then frame_start pulse.
REQ-037 rst_n low mid-CLEAR at address 100 -> outputs reset; clear restarts at address 0 after release.
